truth_sweep: RTL
================

TRUTH_SWEEP -- requirements
Module: truth_sweep

Interface
REQ-001 Parameter N_IN, default 3: number of logic inputs swept; legal range 1..8.
REQ-002 Parameter HOLD, default 1: clock cycles each input vector is held; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: begin a sweep; sampled in IDLE and DONE only.
REQ-006 Port abort, input, 1: terminate a running sweep.
REQ-007 Port lut_x, input, 2**N_IN: truth table for output x; bit k = x for input vector k.
REQ-008 Port lut_y, input, 2**N_IN: truth table for output y; bit k = y for input vector k.
REQ-009 Port vec, output, N_IN: input vector currently applied; vec[N_IN-1] is the MSB input (a), vec[0] the LSB input (c for N_IN=3).
REQ-010 Port res_vec, output, N_IN: vector index of the result currently presented.
REQ-011 Port x, output, 1: registered x result for res_vec.
REQ-012 Port y, output, 1: registered y result for res_vec.
REQ-013 Port valid, output, 1: one-cycle pulse; res_vec/x/y are new.
REQ-014 Port busy, output, 1: high while state is RUN.
REQ-015 Port done, output, 1: high while state is DONE.
REQ-016 Port count_x, output, N_IN+1: number of vectors swept so far with x=1.
REQ-017 Port count_y, output, N_IN+1: number of vectors swept so far with y=1.

Function
REQ-018 FSM states IDLE, RUN, DONE shall be implemented; after reset, state is IDLE.
REQ-019 IDLE with start=1 shall go to RUN; snapshot lut_x/lut_y into internal registers; set vec=0 and hold counter=0; clear count_x and count_y.
REQ-020 During RUN, results shall use only the snapshot, so lut_x/lut_y changes mid-sweep have no effect.
REQ-021 In RUN, vec shall be held for exactly HOLD cycles, then advance by 1.
REQ-022 On the edge ending the last hold cycle of vector k: res_vec=k; x=snap_x[k]; y=snap_y[k]; valid pulses for one cycle; count_x/count_y increment by snap_x[k]/snap_y[k].
REQ-023 Latency: start sampled at edge t0 shall give busy=1, vec=0 after t0; first valid after edge t0+HOLD; vector k result after edge t0+(k+1)*HOLD.
REQ-024 On capture of vector 2**N_IN-1: state shall go to DONE on the same edge; busy=0, done=1; vec shall hold 2**N_IN-1 (no wrap to 0).
REQ-025 Total sweep: done shall rise after edge t0+2**N_IN*HOLD.
REQ-026 In DONE, x, y, res_vec, count_x and count_y shall hold their values until the next start or reset.
REQ-027 DONE with start=1 shall restart exactly as REQ-019 on the same edge; done drops.
REQ-028 RUN with abort=1 shall go to IDLE on that edge; no valid that cycle; counts and vec cleared to 0.
REQ-029 abort shall take priority over a simultaneous final capture.
REQ-030 start shall be ignored while in RUN.
REQ-031 abort shall be ignored in IDLE and DONE.
REQ-032 Counter widths shall never overflow; the maximum count is 2**N_IN, which fits N_IN+1 bits.

Reset
REQ-033 rst_n=0 shall immediately force state=IDLE and set vec, res_vec, x, y, valid, busy, done, count_x, count_y, the hold counter and the snapshots to 0.
REQ-034 Reset asserted mid-sweep shall discard the sweep; after release, the block waits in IDLE for start.
REQ-035 The first rising edge after rst_n release shall act as a normal IDLE cycle.

Verification
REQ-036 N_IN=3, HOLD=1, lut_x=8'b10010110 (XOR3), lut_y=8'b11101000 (majority), start pulse -> valid on 8 consecutive cycles with res_vec 0..7, x=0,1,1,0,1,0,0,1, y=0,0,0,1,0,1,1,1; done after edge t0+8; count_x=4, count_y=4.
REQ-037 N_IN=3, HOLD=10, same LUTs -> each vec value held 10 cycles; valid spacing 10 cycles; done after edge t0+80.
REQ-038 During the REQ-036 sweep, change lut_x to 8'hFF after edge t0+3 -> results unchanged, count_x=4.
REQ-039 Abort asserted in the cycle of the vector-7 capture -> no valid for vector 7; IDLE, counts 0, done never asserted.
REQ-040 rst_n low mid-sweep at vector 4 -> all outputs 0 asynchronously; a new start then performs a full clean sweep.
REQ-041 N_IN=1, HOLD=1, lut_x=2'b10, lut_y=2'b11 -> two valids: (0,x=0,y=1) and (1,x=1,y=1); count_x=1, count_y=2; then start in DONE restarts immediately.

Source files
------------

// File: rtl/truth_sweep.sv
// Truth-table sweeper: steps an N_IN-bit input vector through every value,
// holding each for HOLD cycles, and reports the snapshotted x/y LUT results.
module truth_sweep #(
  parameter int N_IN = 3,
  parameter int HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   lut_x,
  input  logic [2**N_IN-1:0]   lut_y,
  output logic [N_IN-1:0]      vec,
  output logic [N_IN-1:0]      res_vec,
  output logic                 x,
  output logic                 y,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        count_x,
  output logic [N_IN:0]        count_y
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(NV - 1);
  localparam logic [7:0]      LAST_HOLD = 8'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [NV-1:0]   snap_x, snap_y;
  logic [7:0]      hold_cnt;
  logic            load, capture, clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort outranks a capture on the same edge, so it is tested first.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN: if (abort) begin
        state_nxt = IDLE;
        clear     = 1'b1;
      end else if (hold_cnt == LAST_HOLD) begin
        capture = 1'b1;
        if (vec == LAST_VEC) state_nxt = DONE;
      end
      DONE: if (start) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      res_vec  <= '0;
      x        <= 1'b0;
      y        <= 1'b0;
      valid    <= 1'b0;
      count_x  <= '0;
      count_y  <= '0;
      hold_cnt <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
    end else begin
      valid <= capture;
      if (load) begin
        snap_x   <= lut_x;
        snap_y   <= lut_y;
        vec      <= '0;
        hold_cnt <= '0;
        count_x  <= '0;
        count_y  <= '0;
      end else if (clear) begin
        vec      <= '0;
        hold_cnt <= '0;
        count_x  <= '0;
        count_y  <= '0;
      end else if (capture) begin
        res_vec  <= vec;
        x        <= snap_x[vec];
        y        <= snap_y[vec];
        count_x  <= count_x + (N_IN+1)'(snap_x[vec]);
        count_y  <= count_y + (N_IN+1)'(snap_y[vec]);
        hold_cnt <= '0;
        // The final vector stays on vec once the sweep completes.
        if (vec != LAST_VEC) vec <= vec + 1'b1;
      end else if (state == RUN) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
